// File: rtl/sync_fifo_ctrl.sv
// rtl/sync_fifo_ctrl.sv - single-clock FIFO with any depth, standard or FWFT read, thresholds and sticky errors
module sync_fifo_ctrl #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 8,
    parameter  bit FWFT  = 1'b0,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] data_in,
    input  logic             rd_en,
    output logic [WIDTH-1:0] data_out,
    output logic             rd_valid,
    output logic             wr_ack,
    output logic             overflow,
    output logic             underflow,
    output logic [1:0]       err_sticky,
    input  logic             clr_err,
    input  logic [CW-1:0]    af_level,
    input  logic [CW-1:0]    ae_level,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [0:DEPTH-1];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          wr_ack_q, overflow_q, underflow_q;
    logic [1:0]    err_q, err_d;
    logic          wa, ra, ovf_ev, udf_ev;

    // Status flags are pure decodes of the fill counter
    assign full         = (count_q == CW'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= af_level);
    assign almost_empty = (count_q <= ae_level);
    assign count        = count_q;

    assign wr_ack     = wr_ack_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;
    assign err_sticky = err_q;

    // Accept decisions; a full FIFO takes a write only when a read frees a slot in the same cycle
    assign ra     = rd_en & ~empty & ~flush;
    assign wa     = wr_en & (~full | ra) & ~flush;
    assign ovf_ev = wr_en & ~wa & ~flush;
    assign udf_ev = rd_en & ~ra & ~flush;

    // Next-state for pointers (explicit wrap so non-power-of-two depths work), count and error bits
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        err_d    = err_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wa) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            if (ra) rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            case ({wa, ra})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
        if (clr_err) err_d = 2'b00;
        err_d = err_d | {ovf_ev, udf_ev};
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            err_q       <= 2'b00;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            wr_ack_q    <= wa;
            overflow_q  <= ovf_ev;
            underflow_q <= udf_ev;
            err_q       <= err_d;
        end
    end

    // Storage array, deliberately not reset
    always_ff @(posedge clk) begin
        if (wa) mem[wr_ptr_q] <= data_in;
    end

    generate
        if (FWFT) begin : g_fwft
            // Head word is shown directly; rd_en only pops it
            assign data_out = mem[rd_ptr_q];
            assign rd_valid = ~empty;
        end else begin : g_std
            logic [WIDTH-1:0] data_out_q;
            logic             rd_valid_q;

            // Registered read port: data arrives one cycle after an accepted read and is held otherwise
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_out_q <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= ra;
                    if (ra) data_out_q <= mem[rd_ptr_q];
                end
            end

            assign data_out = data_out_q;
            assign rd_valid = rd_valid_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb/tb_sync_fifo_ctrl.sv - directed self-checking bench for sync_fifo_ctrl
module tb_sync_fifo_ctrl;

    localparam int WIDTH = 16;
    localparam int DEPTH = 5;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush, clr_err;
    logic [CW-1:0]    af_level, ae_level;

    logic             s_wr_en, s_rd_en;
    logic [WIDTH-1:0] s_data_in, s_data_out;
    logic             s_rd_valid, s_wr_ack, s_overflow, s_underflow;
    logic [1:0]       s_err;
    logic [CW-1:0]    s_count;
    logic             s_full, s_empty, s_af, s_ae;

    logic             f_wr_en, f_rd_en;
    logic [WIDTH-1:0] f_data_in, f_data_out;
    logic             f_rd_valid, f_wr_ack, f_overflow, f_underflow;
    logic [1:0]       f_err;
    logic [CW-1:0]    f_count;
    logic             f_full, f_empty, f_af, f_ae;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    sync_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(1'b0)) u_std (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(s_wr_en), .data_in(s_data_in),
        .rd_en(s_rd_en), .data_out(s_data_out), .rd_valid(s_rd_valid), .wr_ack(s_wr_ack),
        .overflow(s_overflow), .underflow(s_underflow), .err_sticky(s_err), .clr_err(clr_err),
        .af_level(af_level), .ae_level(ae_level), .count(s_count), .full(s_full),
        .empty(s_empty), .almost_full(s_af), .almost_empty(s_ae)
    );

    sync_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(1'b1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(f_wr_en), .data_in(f_data_in),
        .rd_en(f_rd_en), .data_out(f_data_out), .rd_valid(f_rd_valid), .wr_ack(f_wr_ack),
        .overflow(f_overflow), .underflow(f_underflow), .err_sticky(f_err), .clr_err(clr_err),
        .af_level(af_level), .ae_level(ae_level), .count(f_count), .full(f_full),
        .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [WIDTH-1:0] exp_rd [0:6];

    initial begin
        rst_n = 1'b0; flush = 1'b0; clr_err = 1'b0;
        af_level = 3'd4; ae_level = 3'd1;
        s_wr_en = 1'b0; s_rd_en = 1'b0; s_data_in = '0;
        f_wr_en = 1'b0; f_rd_en = 1'b0; f_data_in = '0;
        exp_rd[0] = 16'h11; exp_rd[1] = 16'h22; exp_rd[2] = 16'h33; exp_rd[3] = 16'h44;
        exp_rd[4] = 16'h55; exp_rd[5] = 16'h60; exp_rd[6] = 16'h61;

        tick(); tick();
        check("rst_count", 32'(s_count), 0);
        check("rst_empty", 32'(s_empty), 1);
        check("rst_ae", 32'(s_ae), 1);
        check("rst_full", 32'(s_full), 0);
        check("rst_af", 32'(s_af), 0);
        check("rst_pulses", {29'd0, s_wr_ack, s_overflow, s_underflow}, 0);
        check("rst_valid_data", {15'd0, s_rd_valid, s_data_out}, 0);
        check("rst_err", 32'(s_err), 0);
        rst_n = 1'b1;

        // Fill to full
        for (int i = 1; i <= DEPTH; i++) begin
            s_wr_en = 1'b1; s_data_in = 16'(i * 'h11);
            tick();
            check($sformatf("fill_ack%0d", i), 32'(s_wr_ack), 1);
            check($sformatf("fill_count%0d", i), 32'(s_count), 32'(i));
            check($sformatf("fill_af%0d", i), 32'(s_af), 32'(i >= 4));
            check($sformatf("fill_full%0d", i), 32'(s_full), 32'(i == 5));
        end
        s_data_in = 16'h99;
        tick();
        check("ovf_pulse", 32'(s_overflow), 1);
        check("ovf_noack", 32'(s_wr_ack), 0);
        check("ovf_err", 32'(s_err), 2);
        check("ovf_count", 32'(s_count), 5);
        s_wr_en = 1'b0;
        tick();
        check("ovf_clear", 32'(s_overflow), 0);

        // Streaming while full, pointers wrap
        for (int k = 0; k < 7; k++) begin
            s_wr_en = 1'b1; s_rd_en = 1'b1; s_data_in = 16'(16'h60 + k);
            tick();
            check($sformatf("wrap_count%0d", k), 32'(s_count), 5);
            check($sformatf("wrap_valid%0d", k), 32'(s_rd_valid), 1);
            check($sformatf("wrap_data%0d", k), 32'(s_data_out), 32'(exp_rd[k]));
        end

        // Drain remaining 0x62..0x66
        s_wr_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("drain_data%0d", k), 32'(s_data_out), 32'(16'h62 + k));
            check($sformatf("drain_count%0d", k), 32'(s_count), 32'(4 - k));
        end
        check("drain_empty", 32'(s_empty), 1);
        tick();
        check("udf_pulse", 32'(s_underflow), 1);
        check("udf_err", 32'(s_err), 3);
        check("udf_novalid", 32'(s_rd_valid), 0);
        check("udf_hold", 32'(s_data_out), 32'h66);
        s_rd_en = 1'b0;
        tick();
        check("udf_clear", 32'(s_underflow), 0);
        clr_err = 1'b1;
        tick();
        check("clr_err", 32'(s_err), 0);
        clr_err = 1'b0;

        // Write and read together while empty
        s_wr_en = 1'b1; s_rd_en = 1'b1; s_data_in = 16'hAB;
        tick();
        check("we_count", 32'(s_count), 1);
        check("we_udf", 32'(s_underflow), 1);
        check("we_ack", 32'(s_wr_ack), 1);
        s_rd_en = 1'b0; s_data_in = 16'hCD;
        tick(); tick();
        check("pre_flush_count", 32'(s_count), 3);

        // Flush with a concurrent write
        flush = 1'b1; s_data_in = 16'hEE;
        tick();
        check("flush_count", 32'(s_count), 0);
        check("flush_empty", 32'(s_empty), 1);
        check("flush_noack", 32'(s_wr_ack), 0);
        flush = 1'b0; s_data_in = 16'h77;
        tick();
        check("post_flush_ack", 32'(s_wr_ack), 1);
        s_wr_en = 1'b0; s_rd_en = 1'b1;
        tick();
        check("post_flush_data", 32'(s_data_out), 32'h77);
        check("post_flush_valid", 32'(s_rd_valid), 1);
        s_rd_en = 1'b0;

        // Asynchronous reset in the middle of a cycle
        s_wr_en = 1'b1; s_data_in = 16'h33;
        tick();
        s_wr_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_count", 32'(s_count), 0);
        check("async_rst_empty", 32'(s_empty), 1);
        check("async_rst_ack", 32'(s_wr_ack), 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("after_rst_empty", 32'(s_empty), 1);

        // FWFT instance
        f_wr_en = 1'b1; f_data_in = 16'hA5;
        tick();
        f_wr_en = 1'b0;
        check("fwft_data", 32'(f_data_out), 32'hA5);
        check("fwft_valid", 32'(f_rd_valid), 1);
        tick();
        check("fwft_hold_valid", 32'(f_rd_valid), 1);
        f_rd_en = 1'b1;
        tick();
        f_rd_en = 1'b0;
        check("fwft_pop_valid", 32'(f_rd_valid), 0);
        check("fwft_pop_empty", 32'(f_empty), 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/sync_fifo_ctrl.md
# sync_fifo_ctrl

Parametrised synchronous FIFO for buffering data between two blocks that share one clock. It supports any depth, including non-power-of-two depths. Read can run in standard (registered-output) mode or first-word-fall-through (FWFT) mode. It also provides programmable almost-full/almost-empty thresholds, a fill-level output, a synchronous flush, and sticky error flags.

## Interface
- WIDTH, 16, data word width in bits (≥1)
- DEPTH, 8, number of entries (≥2, any integer)
- FWFT, 0, read mode: 0 = standard, 1 = first-word-fall-through
- CW (localparam), $clog2(DEPTH+1), width of the count/threshold fields
- clk  in  1  clock; all logic is rising-edge
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous clear of FIFO contents
- wr_en  in  1  write request
- data_in  in  WIDTH  write data
- rd_en  in  1  read request (pop)
- data_out  out  WIDTH  read data
- rd_valid  out  1  data_out holds valid read data
- wr_ack  out  1  registered pulse: the previous-cycle write was accepted
- overflow  out  1  registered pulse: the previous-cycle write was rejected
- underflow  out  1  registered pulse: the previous-cycle read was rejected
- err_sticky  out  2  {ovf, udf}; each bit stays set until clr_err
- clr_err  in  1  clears err_sticky
- af_level  in  CW  almost-full threshold
- ae_level  in  CW  almost-empty threshold
- count  out  CW  current fill level, 0..DEPTH
- full, empty, almost_full, almost_empty  out  1  status flags

## Operation
- Pointers wr_ptr and rd_ptr:
  - Each range 0..DEPTH-1 and wraps from DEPTH-1 to 0; binary-mask wrapping is not permitted.
  - count is a separate register.
- Write accept: wa = wr_en & (!full | ra). A write while full is therefore accepted only together with an accepted read.
- Read accept: ra = rd_en & !empty. A read while empty is always rejected; a simultaneous write does not make it succeed.
- On wa: mem[wr_ptr] <= data_in and wr_ptr advances.
- On ra: rd_ptr advances.
- count update: next count = count + wa − ra.
- Flags are combinational from count:
  - full = (count==DEPTH)
  - empty = (count==0)
  - almost_full = (count ≥ af_level)
  - almost_empty = (count ≤ ae_level)
- Rejected requests:
  - overflow <= wr_en & !wa
  - underflow <= rd_en & !ra
  - wr_ack <= wa
  - err_sticky bits are set by the same conditions.
  - clr_err clears err_sticky; a set in the same cycle as clr_err wins.
- Standard mode (FWFT=0):
  - On ra, data_out <= mem[rd_ptr] and rd_valid <= 1.
  - Otherwise rd_valid <= 0 and data_out holds its value.
- FWFT mode (FWFT=1):
  - data_out = mem[rd_ptr] and rd_valid = !empty, both combinational from registers.
  - rd_en acknowledges the displayed word; the next word appears after the clock edge.
- flush:
  - Sets pointers and count to 0, and forces wa = ra = 0 for that cycle.
  - wr_ack, overflow and underflow are 0 on the following cycle.
  - err_sticky is unaffected by flush. Memory contents are not cleared.
- Memory has no reset.

## Timing
- Reset (asynchronous assertion, synchronous to clk on release):
  - Registers: pointers=0, count=0, data_out=0, rd_valid=0, wr_ack=0, overflow=0, underflow=0, err_sticky=0.
  - Resulting flags: empty=1, full=0, almost_empty=1. almost_full=1 only if af_level==0.
- Write-to-visibility: a word written at edge N is counted at edge N.
  - FWFT: it appears on data_out after edge N.
  - Standard: it can be read by asserting rd_en in cycle N+1, with data after edge N+1.
- Read latency: standard mode 1 cycle from rd_en; FWFT mode 0 cycles.
- wr_ack, overflow and underflow each reflect the request of the preceding cycle and last exactly one cycle.
- Simultaneous wr+rd:
  - When full: both accepted, count stays DEPTH.
  - When empty: write accepted, read rejected, count becomes 1.
  - Otherwise: both accepted, count unchanged.
- Reset asserted mid-transfer clears state immediately. No partial write survives, and the first cycle after release behaves as empty.

## Test plan
- Reset, DEPTH=5, FWFT=0, af_level=4, ae_level=1 → count=0, empty=1, almost_empty=1, full=0, almost_full=0, all pulses 0.
- Write 0x11..0x55 on consecutive cycles → wr_ack=1 for each; count 1..5; almost_full=1 at count 4; full=1 at count 5. A sixth write gives overflow=1 for 1 cycle, err_sticky=2'b10, and count stays 5.
- From full, wr+rd for 7 cycles with data 0x60..0x66 → count stays 5 and pointers wrap past 4→0. Standard-mode data_out returns 0x11..0x55 then 0x60, 0x61, each one cycle after rd_en.
- Drain to empty, then one further rd_en → underflow=1 for 1 cycle and err_sticky=2'b11. After clr_err, err_sticky=0. wr+rd while empty → count=1, underflow=1.
- FWFT=1: write 0xA5 → data_out=0xA5 and rd_valid=1 the cycle after the write, with no rd_en. rd_en for 1 cycle → rd_valid=0 and empty=1.
- With count=3, assert flush together with wr_en → count=0, empty=1, wr_ack=0 next cycle. A subsequent write of 0x77 followed by a read returns 0x77.
